// File: rtl/load_store_buffer.sv
// rtl/load_store_buffer.sv - two-entry load buffer plus two-entry store buffer feeding the address unit
//
// Holds issued memory ops until their base (and store-data) operands arrive
// over the CDB, forms effective addresses, and raises load/store requests
// toward the address unit while keeping stores in order and loads behind
// every store that was already buffered when they issued.
//
// Ports:
//   clk, reset                      clock (rising edge), asynchronous active-high reset
//   issue_valid/issue_is_store      issue handshake; op accepted when issue_valid && issue_ready
//   issue_base_tag/val, offset      base operand (tag 0 = value present) and sign-extended immediate
//   issue_data_tag/val              store-data operand
//   issue_ready                     a free entry of the requested class exists
//   cdb_valid/tag/data              common data bus snoop
//   loadN_tag/addr/valid            load requests (N = 1,2), tags are constant per entry
//   storeN_addr/data/valid          store requests (N = 1,2)
module load_store_buffer #(
  parameter int                 TAG_W   = 4,
  parameter int                 XLEN    = 32,
  parameter logic [TAG_W-1:0]   LD1_TAG = TAG_W'(9),
  parameter logic [TAG_W-1:0]   LD2_TAG = TAG_W'(10)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_is_store,
  input  logic [TAG_W-1:0] issue_base_tag,
  input  logic [XLEN-1:0]  issue_base_val,
  input  logic [XLEN-1:0]  issue_offset,
  input  logic [TAG_W-1:0] issue_data_tag,
  input  logic [XLEN-1:0]  issue_data_val,
  output logic             issue_ready,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic [TAG_W-1:0] load1_tag,
  output logic [TAG_W-1:0] load2_tag,
  output logic [XLEN-1:0]  load1_addr,
  output logic [XLEN-1:0]  load2_addr,
  output logic             load1_valid,
  output logic             load2_valid,
  output logic [XLEN-1:0]  store1_addr,
  output logic [XLEN-1:0]  store2_addr,
  output logic [XLEN-1:0]  store1_data,
  output logic [XLEN-1:0]  store2_data,
  output logic             store1_valid,
  output logic             store2_valid
);

  logic [1:0]       r_ld_busy;
  logic [TAG_W-1:0] r_ld_btag  [2];
  logic [XLEN-1:0]  r_ld_bval  [2];
  logic [XLEN-1:0]  r_ld_off   [2];
  logic [1:0]       r_ld_older [2];

  logic [1:0]       r_st_busy;
  logic [TAG_W-1:0] r_st_btag  [2];
  logic [XLEN-1:0]  r_st_bval  [2];
  logic [XLEN-1:0]  r_st_off   [2];
  logic [TAG_W-1:0] r_st_dtag  [2];
  logic [XLEN-1:0]  r_st_dval  [2];
  logic [1:0]       r_st_older;

  logic [1:0]       w_lv;
  logic [1:0]       w_sv;
  logic [1:0]       w_st_perf;
  logic [1:0]       w_ld_free;
  logic             w_ld_alloc;
  logic             w_st_alloc;
  logic             w_ld_idx;
  logic             w_st_idx;
  logic             w_byp_b;
  logic             w_byp_d;
  logic [TAG_W-1:0] w_iss_btag;
  logic [XLEN-1:0]  w_iss_bval;
  logic [TAG_W-1:0] w_iss_dtag;
  logic [XLEN-1:0]  w_iss_dval;

  assign w_lv[0] = r_ld_busy[0] && (r_ld_btag[0] == '0) && (r_ld_older[0] == 2'b00);
  assign w_lv[1] = r_ld_busy[1] && (r_ld_btag[1] == '0) && (r_ld_older[1] == 2'b00);

  // A store's "older" flag only matters while that other store is still buffered.
  assign w_sv[0] = r_st_busy[0] && (r_st_btag[0] == '0) && (r_st_dtag[0] == '0)
                   && !(r_st_older[0] && r_st_busy[1]);
  assign w_sv[1] = r_st_busy[1] && (r_st_btag[1] == '0) && (r_st_dtag[1] == '0)
                   && !(r_st_older[1] && r_st_busy[0]);

  // Mirrors the address unit's fixed priority: load1 > load2 > store1 > store2.
  assign w_st_perf[0] = w_sv[0] && !(|w_lv);
  assign w_st_perf[1] = w_sv[1] && !(|w_lv) && !w_sv[0];

  assign w_ld_free[0] = cdb_valid && (cdb_tag == LD1_TAG);
  assign w_ld_free[1] = cdb_valid && (cdb_tag == LD2_TAG);

  // Allocation looks only at pre-edge busy bits, so a slot freed this edge waits a cycle.
  assign issue_ready = issue_is_store ? !(&r_st_busy) : !(&r_ld_busy);
  assign w_ld_alloc  = issue_valid && !issue_is_store && !(&r_ld_busy);
  assign w_st_alloc  = issue_valid &&  issue_is_store && !(&r_st_busy);
  assign w_ld_idx    = r_ld_busy[0];
  assign w_st_idx    = r_st_busy[0];

  assign w_byp_b    = cdb_valid && (issue_base_tag != '0) && (issue_base_tag == cdb_tag);
  assign w_byp_d    = cdb_valid && (issue_data_tag != '0) && (issue_data_tag == cdb_tag);
  assign w_iss_btag = w_byp_b ? '0 : issue_base_tag;
  assign w_iss_bval = w_byp_b ? cdb_data : issue_base_val;
  assign w_iss_dtag = w_byp_d ? '0 : issue_data_tag;
  assign w_iss_dval = w_byp_d ? cdb_data : issue_data_val;

  for (genvar g = 0; g < 2; g++) begin : g_ent
    localparam logic G_IDX = (g == 1);
    localparam int   G_OTH = 1 - g;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_ld_busy[g]  <= 1'b0;
        r_ld_btag[g]  <= '0;
        r_ld_bval[g]  <= '0;
        r_ld_off[g]   <= '0;
        r_ld_older[g] <= 2'b00;
      end else if (w_ld_alloc && (w_ld_idx == G_IDX)) begin
        r_ld_busy[g]  <= 1'b1;
        r_ld_btag[g]  <= w_iss_btag;
        r_ld_bval[g]  <= w_iss_bval;
        r_ld_off[g]   <= issue_offset;
        // A store leaving at this same edge is not something to wait for.
        r_ld_older[g] <= r_st_busy & ~w_st_perf;
      end else begin
        if (w_ld_free[g])
          r_ld_busy[g] <= 1'b0;
        if (r_ld_busy[g] && cdb_valid && (r_ld_btag[g] != '0) && (r_ld_btag[g] == cdb_tag)) begin
          r_ld_btag[g] <= '0;
          r_ld_bval[g] <= cdb_data;
        end
        r_ld_older[g] <= r_ld_older[g] & ~w_st_perf;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_st_busy[g]  <= 1'b0;
        r_st_btag[g]  <= '0;
        r_st_bval[g]  <= '0;
        r_st_off[g]   <= '0;
        r_st_dtag[g]  <= '0;
        r_st_dval[g]  <= '0;
        r_st_older[g] <= 1'b0;
      end else if (w_st_alloc && (w_st_idx == G_IDX)) begin
        r_st_busy[g]  <= 1'b1;
        r_st_btag[g]  <= w_iss_btag;
        r_st_bval[g]  <= w_iss_bval;
        r_st_off[g]   <= issue_offset;
        r_st_dtag[g]  <= w_iss_dtag;
        r_st_dval[g]  <= w_iss_dval;
        r_st_older[g] <= r_st_busy[G_OTH] && !w_st_perf[G_OTH];
      end else begin
        if (w_st_perf[g])
          r_st_busy[g] <= 1'b0;
        if (r_st_busy[g] && cdb_valid && (r_st_btag[g] != '0) && (r_st_btag[g] == cdb_tag)) begin
          r_st_btag[g] <= '0;
          r_st_bval[g] <= cdb_data;
        end
        if (r_st_busy[g] && cdb_valid && (r_st_dtag[g] != '0) && (r_st_dtag[g] == cdb_tag)) begin
          r_st_dtag[g] <= '0;
          r_st_dval[g] <= cdb_data;
        end
        if (w_st_perf[G_OTH])
          r_st_older[g] <= 1'b0;
      end
    end
  end

  assign load1_tag    = LD1_TAG;
  assign load2_tag    = LD2_TAG;
  assign load1_addr   = r_ld_bval[0] + r_ld_off[0];
  assign load2_addr   = r_ld_bval[1] + r_ld_off[1];
  assign load1_valid  = w_lv[0];
  assign load2_valid  = w_lv[1];
  assign store1_addr  = r_st_bval[0] + r_st_off[0];
  assign store2_addr  = r_st_bval[1] + r_st_off[1];
  assign store1_data  = r_st_dval[0];
  assign store2_data  = r_st_dval[1];
  assign store1_valid = w_sv[0];
  assign store2_valid = w_sv[1];

endmodule

// File: tb/tb_load_store_buffer.sv
// tb/tb_load_store_buffer.sv - self-checking bench for load_store_buffer
module tb_load_store_buffer;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic        issue_is_store;
  logic [3:0]  issue_base_tag;
  logic [31:0] issue_base_val;
  logic [31:0] issue_offset;
  logic [3:0]  issue_data_tag;
  logic [31:0] issue_data_val;
  logic        issue_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [3:0]  load1_tag, load2_tag;
  logic [31:0] load1_addr, load2_addr;
  logic        load1_valid, load2_valid;
  logic [31:0] store1_addr, store2_addr, store1_data, store2_data;
  logic        store1_valid, store2_valid;

  int checks = 0;
  int errors = 0;

  load_store_buffer dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_is_store(issue_is_store),
    .issue_base_tag(issue_base_tag), .issue_base_val(issue_base_val),
    .issue_offset(issue_offset), .issue_data_tag(issue_data_tag),
    .issue_data_val(issue_data_val), .issue_ready(issue_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .load1_tag(load1_tag), .load2_tag(load2_tag),
    .load1_addr(load1_addr), .load2_addr(load2_addr),
    .load1_valid(load1_valid), .load2_valid(load2_valid),
    .store1_addr(store1_addr), .store2_addr(store2_addr),
    .store1_data(store1_data), .store2_data(store2_data),
    .store1_valid(store1_valid), .store2_valid(store2_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every op carries a global issue sequence number; an op
  // must wait for every still-buffered store that was issued before it.
  typedef struct {
    bit          busy;
    logic [3:0]  btag;
    logic [31:0] bval;
    logic [31:0] off;
    logic [3:0]  dtag;
    logic [31:0] dval;
    int          seq;
  } ent_t;

  ent_t mld[2];
  ent_t mst[2];
  int   next_seq;

  function automatic bit m_store_before(int seq);
    for (int s = 0; s < 2; s++)
      if (mst[s].busy && mst[s].seq < seq) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_lv(int n);
    return mld[n].busy && mld[n].btag == 4'd0 && !m_store_before(mld[n].seq);
  endfunction

  function automatic bit m_sv(int n);
    return mst[n].busy && mst[n].btag == 4'd0 && mst[n].dtag == 4'd0 && !m_store_before(mst[n].seq);
  endfunction

  function automatic bit m_ready(bit st);
    if (st) return !(mst[0].busy && mst[1].busy);
    return !(mld[0].busy && mld[1].busy);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      mld[i] = '{1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 0};
      mst[i] = '{1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 0};
    end
    next_seq = 1;
  endtask

  task automatic m_step();
    bit   lv0, lv1, sv0, sv1;
    bit   perf [2];
    bit   acc;
    int   idx;
    ent_t e;
    lv0 = m_lv(0); lv1 = m_lv(1); sv0 = m_sv(0); sv1 = m_sv(1);
    perf[0] = sv0 && !lv0 && !lv1;
    perf[1] = sv1 && !lv0 && !lv1 && !sv0;
    acc = issue_valid && m_ready(issue_is_store);
    if (issue_is_store) idx = mst[0].busy ? 1 : 0;
    else                idx = mld[0].busy ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      if (cdb_valid && mld[i].busy && mld[i].btag != 0 && mld[i].btag == cdb_tag) begin
        mld[i].btag = 0; mld[i].bval = cdb_data;
      end
      if (cdb_valid && mst[i].busy && mst[i].btag != 0 && mst[i].btag == cdb_tag) begin
        mst[i].btag = 0; mst[i].bval = cdb_data;
      end
      if (cdb_valid && mst[i].busy && mst[i].dtag != 0 && mst[i].dtag == cdb_tag) begin
        mst[i].dtag = 0; mst[i].dval = cdb_data;
      end
      if (perf[i]) mst[i].busy = 1'b0;
    end
    if (cdb_valid && cdb_tag == 4'd9)  mld[0].busy = 1'b0;
    if (cdb_valid && cdb_tag == 4'd10) mld[1].busy = 1'b0;
    if (acc) begin
      e.busy = 1'b1;
      e.btag = (cdb_valid && issue_base_tag != 0 && issue_base_tag == cdb_tag) ? 4'd0 : issue_base_tag;
      e.bval = (cdb_valid && issue_base_tag != 0 && issue_base_tag == cdb_tag) ? cdb_data : issue_base_val;
      e.off  = issue_offset;
      e.dtag = (cdb_valid && issue_data_tag != 0 && issue_data_tag == cdb_tag) ? 4'd0 : issue_data_tag;
      e.dval = (cdb_valid && issue_data_tag != 0 && issue_data_tag == cdb_tag) ? cdb_data : issue_data_val;
      e.seq  = next_seq;
      next_seq++;
      if (issue_is_store) mst[idx] = e;
      else                mld[idx] = e;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_is_store = 0; issue_base_tag = 0; issue_base_val = 0;
    issue_offset = 0; issue_data_tag = 0; issue_data_val = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic issue(input bit st, input logic [3:0] bt, input logic [31:0] bv,
                       input logic [31:0] off, input logic [3:0] dt, input logic [31:0] dv);
    issue_valid = 1; issue_is_store = st; issue_base_tag = bt; issue_base_val = bv;
    issue_offset = off; issue_data_tag = dt; issue_data_val = dv;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cycle(); cycle();
    reset = 0;
    m_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({load1_valid, load2_valid, store1_valid, store2_valid} !== 4'b0000) begin errors++; $display("FAIL reset_valids: got %b exp 0000", {load1_valid, load2_valid, store1_valid, store2_valid}); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_ld: got %b exp 1", issue_ready); end
    issue_is_store = 1; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_st: got %b exp 1", issue_ready); end
    checks++; if ({load1_addr, load2_addr, store1_addr, store2_data} !== 128'd0) begin errors++; $display("FAIL reset_addr: got %h exp 0", {load1_addr, load2_addr, store1_addr, store2_data}); end
    idle();
  endtask

  task automatic test_load_basic();
    do_reset();
    issue(0, 4'd0, 32'h100, 32'h8, 4'd0, 32'd0);
    cycle(); idle(); #1;
    checks++; if (load1_valid !== 1'b1) begin errors++; $display("FAIL ld_basic_valid: got %b exp 1", load1_valid); end
    checks++; if (load1_addr !== 32'h108) begin errors++; $display("FAIL ld_basic_addr: got %h exp 108", load1_addr); end
    checks++; if (load1_tag !== 4'd9 || load2_tag !== 4'd10) begin errors++; $display("FAIL ld_tags: got %0d/%0d exp 9/10", load1_tag, load2_tag); end
  endtask

  task automatic test_cdb_wakeup();
    do_reset();
    issue(0, 4'd3, 32'h0, 32'hFFFF_FFFC, 4'd0, 32'd0);
    cycle(); idle(); #1;
    checks++; if (load1_valid !== 1'b0) begin errors++; $display("FAIL wake_wait: got %b exp 0", load1_valid); end
    cdb(4'd3, 32'h2000);
    cycle(); idle(); #1;
    checks++; if (load1_valid !== 1'b1) begin errors++; $display("FAIL wake_valid: got %b exp 1", load1_valid); end
    checks++; if (load1_addr !== 32'h1FFC) begin errors++; $display("FAIL wake_addr: got %h exp 1ffc", load1_addr); end
    cdb(4'd9, 32'h0);
    cycle(); idle(); #1;
    checks++; if (load1_valid !== 1'b0) begin errors++; $display("FAIL ld_free: got %b exp 0", load1_valid); end
  endtask

  task automatic test_store_load_order();
    do_reset();
    issue(1, 4'd0, 32'h40, 32'h0, 4'd5, 32'h0);
    cycle();
    issue(0, 4'd0, 32'h80, 32'h0, 4'd0, 32'h0);
    cycle(); idle(); #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (load1_valid !== 1'b0 || store1_valid !== 1'b0) begin errors++; $display("FAIL sl_blocked: got ld %b st %b exp 0 0", load1_valid, store1_valid); end
      cycle();
    end
    cdb(4'd5, 32'hDEAD);
    cycle(); idle(); #1;
    checks++; if (store1_valid !== 1'b1 || load1_valid !== 1'b0) begin errors++; $display("FAIL sl_store_up: got st %b ld %b exp 1 0", store1_valid, load1_valid); end
    checks++; if (store1_addr !== 32'h40 || store1_data !== 32'hDEAD) begin errors++; $display("FAIL sl_store_ad: got %h/%h exp 40/dead", store1_addr, store1_data); end
    cycle();
    checks++; if (load1_valid !== 1'b1 || store1_valid !== 1'b0) begin errors++; $display("FAIL sl_load_up: got ld %b st %b exp 1 0", load1_valid, store1_valid); end
    checks++; if (load1_addr !== 32'h80) begin errors++; $display("FAIL sl_load_addr: got %h exp 80", load1_addr); end
  endtask

  task automatic test_store_order();
    do_reset();
    issue(1, 4'd0, 32'h10, 32'h0, 4'd5, 32'h0);
    cycle();
    issue(1, 4'd0, 32'h20, 32'h0, 4'd6, 32'h0);
    cycle(); idle();
    cdb(4'd6, 32'h66);
    cycle(); idle(); #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (store2_valid !== 1'b0 || store1_valid !== 1'b0) begin errors++; $display("FAIL ss_hold: got s1 %b s2 %b exp 0 0", store1_valid, store2_valid); end
      cycle();
    end
    cdb(4'd5, 32'h55);
    cycle(); idle(); #1;
    checks++; if (store1_valid !== 1'b1 || store2_valid !== 1'b0) begin errors++; $display("FAIL ss_first: got s1 %b s2 %b exp 1 0", store1_valid, store2_valid); end
    cycle();
    checks++; if (store1_valid !== 1'b0 || store2_valid !== 1'b1) begin errors++; $display("FAIL ss_second: got s1 %b s2 %b exp 0 1", store1_valid, store2_valid); end
    checks++; if (store2_addr !== 32'h20 || store2_data !== 32'h66) begin errors++; $display("FAIL ss_second_ad: got %h/%h exp 20/66", store2_addr, store2_data); end
    cycle();
    checks++; if (store2_valid !== 1'b0) begin errors++; $display("FAIL ss_done: got %b exp 0", store2_valid); end
  endtask

  task automatic test_full();
    do_reset();
    issue(0, 4'd0, 32'h1, 32'h0, 4'd0, 32'h0); cycle();
    issue(0, 4'd0, 32'h2, 32'h0, 4'd0, 32'h0); cycle();
    issue(1, 4'd0, 32'h3, 32'h0, 4'd5, 32'h0); cycle();
    issue(1, 4'd0, 32'h4, 32'h0, 4'd5, 32'h0); cycle();
    idle(); #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ld_ready: got %b exp 0", issue_ready); end
    issue_is_store = 1; #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_st_ready: got %b exp 0", issue_ready); end
    idle();
    cdb(4'd9, 32'h0);
    cycle(); idle(); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL freed_ld_ready: got %b exp 1", issue_ready); end
    issue_is_store = 1; #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL freed_st_ready: got %b exp 0", issue_ready); end
    idle();
  endtask

  task automatic test_bypass_reset();
    do_reset();
    issue(0, 4'd7, 32'hBAD, 32'h4, 4'd0, 32'h0);
    cdb(4'd7, 32'h30);
    cycle(); idle(); #1;
    checks++; if (load1_valid !== 1'b1 || load1_addr !== 32'h34) begin errors++; $display("FAIL bypass: got v %b addr %h exp 1 34", load1_valid, load1_addr); end
    issue(0, 4'd2, 32'h0, 32'h0, 4'd0, 32'h0);
    cycle(); idle(); #1;
    checks++; if (load2_valid !== 1'b0 || issue_ready !== 1'b0) begin errors++; $display("FAIL bypass_wait: got v2 %b rdy %b exp 0 0", load2_valid, issue_ready); end
    #2; reset = 1; #1;
    checks++; if ({load1_valid, load2_valid, store1_valid, store2_valid} !== 4'b0000) begin errors++; $display("FAIL async_reset: got %b exp 0000", {load1_valid, load2_valid, store1_valid, store2_valid}); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b exp 1", issue_ready); end
    cycle(); reset = 0; cycle();
    checks++; if ({load1_valid, load2_valid, store1_valid, store2_valid} !== 4'b0000) begin errors++; $display("FAIL post_reset: got %b exp 0000", {load1_valid, load2_valid, store1_valid, store2_valid}); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      issue_valid    = ($urandom_range(0, 2) != 0);
      issue_is_store = $urandom_range(0, 1);
      issue_base_tag = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 7));
      issue_base_val = $urandom;
      issue_offset   = $urandom;
      issue_data_tag = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 7));
      issue_data_val = $urandom;
      cdb_valid      = ($urandom_range(0, 4) < 3);
      cdb_tag        = 4'($urandom_range(1, 10));
      cdb_data       = $urandom;
      #1;
      checks++; if (issue_ready !== m_ready(issue_is_store)) begin errors++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, issue_ready, m_ready(issue_is_store)); end
      checks++; if ({load1_valid, load2_valid} !== {m_lv(0), m_lv(1)}) begin errors++; $display("FAIL rnd_lv c%0d: got %b exp %b", c, {load1_valid, load2_valid}, {m_lv(0), m_lv(1)}); end
      checks++; if ({store1_valid, store2_valid} !== {m_sv(0), m_sv(1)}) begin errors++; $display("FAIL rnd_sv c%0d: got %b exp %b", c, {store1_valid, store2_valid}, {m_sv(0), m_sv(1)}); end
      if (m_lv(0)) begin checks++; if (load1_addr !== mld[0].bval + mld[0].off) begin errors++; $display("FAIL rnd_l1a c%0d: got %h exp %h", c, load1_addr, mld[0].bval + mld[0].off); end end
      if (m_lv(1)) begin checks++; if (load2_addr !== mld[1].bval + mld[1].off) begin errors++; $display("FAIL rnd_l2a c%0d: got %h exp %h", c, load2_addr, mld[1].bval + mld[1].off); end end
      if (m_sv(0)) begin checks++; if ({store1_addr, store1_data} !== {mst[0].bval + mst[0].off, mst[0].dval}) begin errors++; $display("FAIL rnd_s1 c%0d: got %h/%h exp %h/%h", c, store1_addr, store1_data, mst[0].bval + mst[0].off, mst[0].dval); end end
      if (m_sv(1)) begin checks++; if ({store2_addr, store2_data} !== {mst[1].bval + mst[1].off, mst[1].dval}) begin errors++; $display("FAIL rnd_s2 c%0d: got %h/%h exp %h/%h", c, store2_addr, store2_data, mst[1].bval + mst[1].off, mst[1].dval); end end
      m_step();
      cycle();
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    m_reset();
    test_reset();
    test_load_basic();
    test_cdb_wakeup();
    test_store_load_order();
    test_store_order();
    test_full();
    test_bypass_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
